mem_arbiter: RTL
================

# mem_arbiter

Two-requester arbiter sharing the single byte-wide memory port between the multicycle MIPS core and a loader/debug port. It serialises accesses with a round-robin policy and sequences each one through a fixed-latency memory. It returns read data and a one-cycle acknowledge to the winning requester. It sits between the `mips` top-level memory signals (adr, writedata, memread/memwrite, memdata) and the memory array; the core waits on `core_ack` before advancing its state machine.

## Interface
- `WIDTH`, 8, data width in bits
- `ADDRBITS`, 8, address width in bits
- `MEMLAT`, 1, memory read latency: cycles after the `mem_en` cycle until `mem_rdata` is valid (≥1)

Ports:
- `clk` in 1: single clock, rising edge
- `rst` in 1: reset, asynchronous, active-low
- `core_req` / `ldr_req` in 1: access request; held until ack
- `core_we` / `ldr_we` in 1: 1 = write, 0 = read
- `core_adr` / `ldr_adr` in ADDRBITS: address
- `core_wdata` / `ldr_wdata` in WIDTH: write data
- `core_ack` / `ldr_ack` out 1: one-cycle completion pulse
- `core_rdata` / `ldr_rdata` out WIDTH: read data; valid from the ack cycle, held until that port's next ack
- `mem_en` out 1: memory strobe, one cycle per access
- `mem_we` out 1: write enable, qualified by `mem_en`
- `mem_adr` out ADDRBITS: memory address
- `mem_wdata` out WIDTH: memory write data
- `mem_rdata` in WIDTH: memory read data
- `busy` out 1: transaction in progress (state ≠ IDLE)
- `owner` out 1: current/last grantee, 0 = core, 1 = loader

## Operation
- FSM states: IDLE, ACCESS, WAIT, DONE.
- IDLE:
  - If no request, stay in IDLE.
  - If exactly one requester is asserting req, grant it.
  - If both are asserting req, grant the port that is not `owner`.
  - On grant: latch the winner's we/adr/wdata into internal registers, set `owner`, go to ACCESS.
- ACCESS: `mem_en`=1 and `mem_we`=latched we for exactly one cycle. Load the latency counter with MEMLAT−1. Go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter reaches 0, capture `mem_rdata` into the grantee's rdata register (reads only) and go to DONE.
  - WAIT lasts MEMLAT cycles.
- DONE: pulse the grantee's ack. Go to IDLE.
- Writes follow the same state sequence as reads. rdata registers are not modified by writes.
- req is sampled only in IDLE. A requester wanting a single access deasserts req in its ack cycle. If req is still high in the following IDLE cycle, it starts a new transaction.
- Changes to req/we/adr/wdata after the grant have no effect on the current transaction. A dropped req still completes, and ack still pulses.
- `mem_adr`/`mem_wdata` show the latched values in every state. `mem_en`=0 outside ACCESS.

## Timing
- Reset values: state IDLE, `mem_en`=0, `mem_we`=0, `mem_adr`=0, `mem_wdata`=0, both acks 0, both rdata 0, `busy`=0, `owner`=1. With `owner`=1, the core wins the first contested arbitration.
- Request sampled in IDLE at cycle t:
  - `mem_en` at t+1
  - `mem_rdata` sampled at t+1+MEMLAT
  - ack and rdata valid at t+2+MEMLAT
  - IDLE at t+3+MEMLAT
- MEMLAT=1: ack 3 cycles after request. Maximum throughput is one access per 4 cycles.
- Both ports requesting continuously: grants alternate core, loader, core, … with no starvation.
- Reset asserted mid-transaction: outputs return immediately to reset values, the transaction is aborted, and no ack is issued.
- Both ack outputs are never high in the same cycle. At most one `mem_en` per transaction.

## Structure
- Shared package `mips_pkg`:
  - `arb_state_t` enum (IDLE, ACCESS, WAIT, DONE)
  - port index constants `PORT_CORE`=0 and `PORT_LDR`=1
- Sub-module `rr_arb2`: combinational two-way round-robin picker. Inputs: the two reqs and `owner`. Outputs: grant valid and grant index.
- Latency counter width: $clog2(MEMLAT+1).

## Test plan
- Single core read, MEMLAT=1: `core_req` with adr 0x10; memory returns 0xA5 → `mem_en` at t+1 with `mem_adr`=0x10, `core_ack` at t+3, `core_rdata`=0xA5.
- Loader write: adr 0x20, wdata 0x3C → `mem_en`=`mem_we`=1 for one cycle with 0x20/0x3C. `ldr_ack` at t+3. `ldr_rdata` unchanged.
- Simultaneous requests from reset, both held high for 4 transactions → owner sequence 0,1,0,1. Each ack arrives 4 cycles after the previous one.
- MEMLAT=3 read → `mem_en` at t+1, ack at t+5, data equals `mem_rdata` sampled at t+4.
- `core_adr` changed from 0x10 to 0x55 during WAIT → `mem_adr` stays 0x10, and the ack still completes.
- `rst` low during WAIT → `busy`=0, `mem_en`=0, no ack, `owner`=1. The next request completes normally.

Source files
------------

// File: rtl/mips_pkg.sv
// Types and constants shared by the memory arbiter and its round-robin picker.
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } arb_state_t;

    localparam logic PORT_CORE = 1'b0;
    localparam logic PORT_LDR  = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: a lone requester wins; on contention the port
// that did not hold the memory last time wins.
module rr_arb2
    import mips_pkg::*;
(
    input  logic core_req_i,
    input  logic ldr_req_i,
    input  logic owner_i,
    output logic gnt_valid_o,
    output logic gnt_idx_o
);

    always_comb begin
        gnt_valid_o = core_req_i | ldr_req_i;
        gnt_idx_o   = PORT_CORE;
        if (core_req_i && ldr_req_i) begin
            gnt_idx_o = ~owner_i;
        end else if (ldr_req_i) begin
            gnt_idx_o = PORT_LDR;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one fixed-latency byte memory between the MIPS core and the loader port.
// Each access runs IDLE -> ACCESS -> WAIT (MEMLAT cycles) -> DONE with a one-cycle ack.
module mem_arbiter
    import mips_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int ADDRBITS = 8,
    parameter int MEMLAT   = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                core_req,
    input  logic                core_we,
    input  logic [ADDRBITS-1:0] core_adr,
    input  logic [WIDTH-1:0]    core_wdata,
    output logic                core_ack,
    output logic [WIDTH-1:0]    core_rdata,
    input  logic                ldr_req,
    input  logic                ldr_we,
    input  logic [ADDRBITS-1:0] ldr_adr,
    input  logic [WIDTH-1:0]    ldr_wdata,
    output logic                ldr_ack,
    output logic [WIDTH-1:0]    ldr_rdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDRBITS-1:0] mem_adr,
    output logic [WIDTH-1:0]    mem_wdata,
    input  logic [WIDTH-1:0]    mem_rdata,
    output logic                busy,
    output logic                owner,
    output arb_state_t          dbg_state
);

    localparam int             CW       = $clog2(MEMLAT + 1);
    localparam logic [CW-1:0]  CNT_LOAD = CW'(MEMLAT - 1);

    arb_state_t          state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [ADDRBITS-1:0] adr_q, adr_d;
    logic [WIDTH-1:0]    wdata_q, wdata_d;
    logic                owner_q, owner_d;
    logic [WIDTH-1:0]    core_rdata_q, core_rdata_d;
    logic [WIDTH-1:0]    ldr_rdata_q, ldr_rdata_d;
    logic                gnt_valid, gnt_idx;

    rr_arb2 u_rr_arb2 (
        .core_req_i  (core_req),
        .ldr_req_i   (ldr_req),
        .owner_i     (owner_q),
        .gnt_valid_o (gnt_valid),
        .gnt_idx_o   (gnt_idx)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        adr_d        = adr_q;
        wdata_d      = wdata_q;
        owner_d      = owner_q;
        core_rdata_d = core_rdata_q;
        ldr_rdata_d  = ldr_rdata_q;
        unique case (state_q)
            IDLE: begin
                // Requester fields are captured once here; later changes are ignored.
                if (gnt_valid) begin
                    owner_d = gnt_idx;
                    we_d    = (gnt_idx == PORT_LDR) ? ldr_we    : core_we;
                    adr_d   = (gnt_idx == PORT_LDR) ? ldr_adr   : core_adr;
                    wdata_d = (gnt_idx == PORT_LDR) ? ldr_wdata : core_wdata;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                cnt_d   = CNT_LOAD;
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    if (!we_q) begin
                        if (owner_q == PORT_LDR) ldr_rdata_d  = mem_rdata;
                        else                     core_rdata_d = mem_rdata;
                    end
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            we_q         <= 1'b0;
            adr_q        <= '0;
            wdata_q      <= '0;
            owner_q      <= PORT_LDR;
            core_rdata_q <= '0;
            ldr_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            adr_q        <= adr_d;
            wdata_q      <= wdata_d;
            owner_q      <= owner_d;
            core_rdata_q <= core_rdata_d;
            ldr_rdata_q  <= ldr_rdata_d;
        end
    end

    assign mem_en     = (state_q == ACCESS);
    assign mem_we     = mem_en & we_q;
    assign mem_adr    = adr_q;
    assign mem_wdata  = wdata_q;
    assign busy       = (state_q != IDLE);
    assign owner      = owner_q;
    assign core_ack   = (state_q == DONE) && (owner_q == PORT_CORE);
    assign ldr_ack    = (state_q == DONE) && (owner_q == PORT_LDR);
    assign core_rdata = core_rdata_q;
    assign ldr_rdata  = ldr_rdata_q;
    assign dbg_state  = state_q;

endmodule
